// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-owner tag,
// starvation counter width and the per-master request bundle.
package dmem_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam int STARVE_W = 4;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

endpackage

// File: rtl/dmem_arb_rsp.sv
// Read-owner tag register and read-data routing for the data-memory arbiter.
// Memory returns data one cycle after the read grant; the tag says whose it is.
module dmem_arb_rsp
  import dmem_arb_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        core_rd,
  input  logic        ext_rd,
  input  logic [31:0] mem_rdata,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata
);

  owner_e own_q, own_d;

  always_comb begin
    own_d = OWN_NONE;
    if (core_rd)     own_d = OWN_CORE;
    else if (ext_rd) own_d = OWN_EXT;
  end

  // Async clear drops any read in flight, so nothing returns after reset.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) own_q <= OWN_NONE;
    else          own_q <= own_d;
  end

  assign core_rvalid = (own_q == OWN_CORE);
  assign ext_rvalid  = (own_q == OWN_EXT);
  assign core_rdata  = core_rvalid ? mem_rdata : 32'h0;
  assign ext_rdata   = ext_rvalid  ? mem_rdata : 32'h0;

endmodule

// File: rtl/dmem_arb.sv
// Two-master data-memory arbiter: core has priority, ext may lock bursts.
// Define DMEM_ARB_STARVE_EN to build the ext anti-starvation counter.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_stall,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic        ext_we,
  input  logic [3:0]  ext_be,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_wbe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_lim_chk
    $error("dmem_arb: STARVE_LIM out of range 1..15");
  end

  arb_state_e state_q;
  logic       force_ext;
  logic       any_gnt;
  mreq_t      core_m, ext_m, sel_m;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);
  logic [STARVE_W-1:0] starve_q, starve_d;

  // Saturated count wins ext exactly one grant; that grant clears it.
  assign force_ext = ext_req && (starve_q == LIM);

  always_comb begin
    starve_d = starve_q;
    if (ext_gnt || !ext_req)  starve_d = '0;
    else if (starve_q != LIM) starve_d = starve_q + STARVE_W'(1);
  end

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  assign force_ext = 1'b0;
`endif

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (rst_sys) begin
      if (state_q == ST_LOCKED) begin
        ext_gnt = ext_req;
      end else begin
        core_gnt = core_req & ~force_ext;
        ext_gnt  = ext_req & ~core_gnt;
      end
    end
  end

  assign core_stall = rst_sys & core_req & ~core_gnt;

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (ext_gnt && ext_lock)    state_q <= ST_LOCKED;
        ST_LOCKED: if (!ext_lock || !ext_req) state_q <= ST_IDLE;
        default:                               state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_m  = '{we: core_we, be: core_be, addr: core_addr, wdata: core_wdata};
  assign ext_m   = '{we: ext_we,  be: ext_be,  addr: ext_addr,  wdata: ext_wdata};
  assign sel_m   = ext_gnt ? ext_m : core_m;
  assign any_gnt = core_gnt | ext_gnt;

  assign mem_wen   = any_gnt &  sel_m.we;
  assign mem_ren   = any_gnt & ~sel_m.we;
  assign mem_wbe   = mem_wen ? sel_m.be : 4'h0;
  assign mem_addr  = any_gnt ? sel_m.addr  : 32'h0;
  assign mem_wdata = any_gnt ? sel_m.wdata : 32'h0;

  dmem_arb_rsp u_rsp (
    .clk_sys     (clk_sys),
    .rst_sys     (rst_sys),
    .core_rd     (core_gnt & ~core_we),
    .ext_rd      (ext_gnt & ~ext_we),
    .mem_rdata   (mem_rdata),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .ext_rvalid  (ext_rvalid),
    .ext_rdata   (ext_rdata)
  );

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: arbitration-rule model checked every cycle, plus
// directed literal checks for the headline scenarios and a random phase.
module tb_dmem_arb;

  localparam int LIM = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        ext_req, ext_lock, ext_we;
  logic [3:0]  ext_be;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_wen, mem_ren;
  logic [3:0]  mem_wbe;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  dmem_arb #(.STARVE_LIM(LIM)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_be(ext_be),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wbe(mem_wbe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_locked;
  int m_cnt;
  int m_owner;   // 0 none, 1 core, 2 ext: who gets the data returning now

  function automatic void model_gnt(output bit cg, output bit eg);
    cg = 1'b0;
    eg = 1'b0;
    if (rst_sys !== 1'b1) return;
    if (m_locked)                             eg = ext_req;
    else if (STARVE && ext_req && m_cnt >= LIM) eg = 1'b1;
    else begin
      cg = core_req;
      eg = ext_req && !core_req;
    end
  endfunction

  always @(posedge clk_sys or negedge rst_sys) begin : model_upd
    bit cg, eg;
    if (!rst_sys) begin
      m_locked = 1'b0;
      m_cnt    = 0;
      m_owner  = 0;
    end else begin
      model_gnt(cg, eg);
      m_owner  = (cg && !core_we) ? 1 : ((eg && !ext_we) ? 2 : 0);
      m_locked = m_locked ? (ext_req && ext_lock) : (eg && ext_lock);
      m_cnt    = (ext_req && !eg) ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
    end
  end

  always @(negedge clk_sys) begin : cmp
    bit          cg, eg, any, we;
    logic [3:0]  be;
    logic [31:0] ad, wd;
    model_gnt(cg, eg);
    any = cg | eg;
    we  = eg ? ext_we    : core_we;
    be  = eg ? ext_be    : core_be;
    ad  = eg ? ext_addr  : core_addr;
    wd  = eg ? ext_wdata : core_wdata;
    chk("m_core_gnt",    core_gnt,    cg);
    chk("m_ext_gnt",     ext_gnt,     eg);
    chk("m_core_stall",  core_stall,  (rst_sys === 1'b1) && core_req && !cg);
    chk("m_mem_wen",     mem_wen,     any && we);
    chk("m_mem_ren",     mem_ren,     any && !we);
    chk("m_mem_wbe",     mem_wbe,     (any && we) ? be : 4'h0);
    chk("m_mem_addr",    mem_addr,    any ? ad : 32'h0);
    chk("m_mem_wdata",   mem_wdata,   any ? wd : 32'h0);
    chk("m_core_rvalid", core_rvalid, m_owner == 1);
    chk("m_core_rdata",  core_rdata,  (m_owner == 1) ? mem_rdata : 32'h0);
    chk("m_ext_rvalid",  ext_rvalid,  m_owner == 2);
    chk("m_ext_rdata",   ext_rdata,   (m_owner == 2) ? mem_rdata : 32'h0);
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_lock = 0; ext_we = 0; ext_be = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic next();
    @(posedge clk_sys);
    #1;
  endtask

  bit eg_seen, cs_seen;

  initial begin
    idle_in();
    mem_rdata = 32'h0;
    rst_sys   = 1'b1;
    #2 rst_sys = 1'b0;
    core_req  = 1'b1;
    core_addr = 32'h40;
    @(negedge clk_sys);
    chk("rst_core_gnt",    core_gnt,    0);
    chk("rst_core_stall",  core_stall,  0);
    chk("rst_mem_ren",     mem_ren,     0);
    chk("rst_mem_addr",    mem_addr,    0);
    chk("rst_core_rvalid", core_rvalid, 0);
    next();
    idle_in();
    rst_sys = 1'b1;

    // single core read
    next();
    core_req = 1; core_we = 0; core_be = 4'hF; core_addr = 32'h100;
    @(negedge clk_sys);
    chk("rd_core_gnt", core_gnt, 1);
    chk("rd_mem_ren",  mem_ren,  1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_wbe",  mem_wbe,  4'h0);
    next();
    idle_in();
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk_sys);
    chk("rd_core_rvalid", core_rvalid, 1);
    chk("rd_core_rdata",  core_rdata,  32'hDEADBEEF);
    chk("rd_ext_rvalid",  ext_rvalid,  0);
    chk("rd_ext_rdata",   ext_rdata,   0);
    next();
    @(negedge clk_sys);
    chk("rd_rvalid_once", core_rvalid, 0);

    // contention: core first, then ext write
    next();
    core_req = 1; core_addr = 32'h104;
    ext_req = 1; ext_we = 1; ext_be = 4'h3; ext_addr = 32'h200; ext_wdata = 32'h12345678;
    @(negedge clk_sys);
    chk("ct_core_gnt", core_gnt, 1);
    chk("ct_ext_gnt",  ext_gnt,  0);
    next();
    core_req = 0;
    @(negedge clk_sys);
    chk("ct_ext_gnt2",   ext_gnt,   1);
    chk("ct_mem_wen",    mem_wen,   1);
    chk("ct_mem_addr",   mem_addr,  32'h200);
    chk("ct_mem_wbe",    mem_wbe,   4'h3);
    chk("ct_mem_wdata",  mem_wdata, 32'h12345678);
    next();
    idle_in();
    mem_rdata = 32'h55;
    @(negedge clk_sys);
    chk("ct_wr_no_rvalid", ext_rvalid, 0);

    // locked burst of 3 ext reads, core waiting, then ext drops req with lock high
    next();
    ext_req = 1; ext_lock = 1; ext_we = 0; ext_addr = 32'h300;
    @(negedge clk_sys);
    chk("lk_ext_gnt0", ext_gnt, 1);
    next();
    core_req = 1; core_addr = 32'h108; ext_addr = 32'h304; mem_rdata = 32'hA0;
    @(negedge clk_sys);
    chk("lk_ext_gnt1",   ext_gnt,    1);
    chk("lk_core_stall", core_stall, 1);
    chk("lk_ext_rdata0", ext_rdata,  32'hA0);
    next();
    ext_addr = 32'h308; mem_rdata = 32'hA1;
    @(negedge clk_sys);
    chk("lk_ext_gnt2",   ext_gnt,   1);
    chk("lk_ext_rdata1", ext_rdata, 32'hA1);
    next();
    ext_req = 0; mem_rdata = 32'hA2;
    @(negedge clk_sys);
    chk("lk_hold_core",  core_gnt,   0);
    chk("lk_ext_rvalid", ext_rvalid, 1);
    chk("lk_ext_rdata2", ext_rdata,  32'hA2);
    next();
    @(negedge clk_sys);
    chk("lk_core_back", core_gnt, 1);
    next();
    idle_in();
    @(negedge clk_sys);

    // both requesting continuously
    next();
    core_req = 1; core_addr = 32'h10; ext_req = 1; ext_addr = 32'h20;
`ifdef DMEM_ARB_STARVE_EN
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_sys);
      chk($sformatf("sv_ext_gnt_c%0d", i),    ext_gnt,    i == 5);
      chk($sformatf("sv_core_stall_c%0d", i), core_stall, i == 5);
      next();
    end
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_sys);
      chk($sformatf("ns_ext_gnt_c%0d", i), ext_gnt, 0);
      next();
    end
`endif
    idle_in();
    @(negedge clk_sys);

    // reset hits right after a granted core read
    next();
    core_req = 1; core_addr = 32'h400;
    @(negedge clk_sys);
    chk("rr_core_gnt", core_gnt, 1);
    next();
    rst_sys = 0; mem_rdata = 32'hCAFEF00D;
    @(negedge clk_sys);
    chk("rr_no_rvalid", core_rvalid, 0);
    chk("rr_rdata0",    core_rdata,  0);
    chk("rr_gnt0",      core_gnt,    0);
    chk("rr_stall0",    core_stall,  0);
    chk("rr_mem_ren0",  mem_ren,     0);
    next();
    rst_sys = 1; core_addr = 32'h404;
    @(negedge clk_sys);
    chk("rr_gnt_resume",  core_gnt,    1);
    chk("rr_addr_resume", mem_addr,    32'h404);
    chk("rr_rvalid_post", core_rvalid, 0);
    next();
    core_req = 0; mem_rdata = 32'h77;
    @(negedge clk_sys);
    chk("rr_rvalid_new", core_rvalid, 1);
    chk("rr_rdata_new",  core_rdata,  32'h77);

    // random phase, respecting hold rules of both masters
    eg_seen = 1'b1;
    cs_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      next();
      if (!cs_seen) begin
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = $urandom_range(0, 1) == 1;
        core_be    = 4'($urandom_range(0, 15));
        core_addr  = $urandom;
        core_wdata = $urandom;
      end
      if (!ext_req || eg_seen) begin
        ext_req   = ($urandom_range(0, 2) != 0);
        ext_lock  = ($urandom_range(0, 2) == 0);
        ext_we    = $urandom_range(0, 1) == 1;
        ext_be    = 4'($urandom_range(0, 15));
        ext_addr  = $urandom;
        ext_wdata = $urandom;
      end
      mem_rdata = $urandom;
      rst_sys   = ($urandom_range(0, 60) != 0);
      @(negedge clk_sys);
      eg_seen = ext_gnt;
      cs_seen = core_stall;
    end

    next();
    idle_in();
    rst_sys = 1'b1;
    @(negedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
